// File: rtl/trivium_pkg.sv
// trivium_pkg: shared FSM encoding, state geometry and 1-based tap positions for the Trivium core
package trivium_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2} state_e;
  localparam int STATE_W = 288;
  localparam int INIT_ROUNDS_DEF = 1152;
  localparam int REG_A_END = 93;
  localparam int REG_B_END = 177;
  localparam int T1_A = 66;
  localparam int T1_B = 93;
  localparam int T2_A = 162;
  localparam int T2_B = 177;
  localparam int T3_A = 243;
  localparam int T3_B = 288;
  localparam int T1_AND_A = 91;
  localparam int T1_AND_B = 92;
  localparam int T1_X = 171;
  localparam int T2_AND_A = 175;
  localparam int T2_AND_B = 176;
  localparam int T2_X = 264;
  localparam int T3_AND_A = 286;
  localparam int T3_AND_B = 287;
  localparam int T3_X = 69;
endpackage

// File: rtl/trivium_round.sv
// trivium_round: one combinational Trivium round; state_i -> next_state_o, keystream bit z_o
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  output logic [STATE_W-1:0] next_state_o,
  output logic               z_o
);
  logic t1, t2, t3, t1_n, t2_n, t3_n;
  always_comb begin
    t1 = state_i[T1_A-1] ^ state_i[T1_B-1];
    t2 = state_i[T2_A-1] ^ state_i[T2_B-1];
    t3 = state_i[T3_A-1] ^ state_i[T3_B-1];
    z_o = t1 ^ t2 ^ t3;
    t1_n = t1 ^ (state_i[T1_AND_A-1] & state_i[T1_AND_B-1]) ^ state_i[T1_X-1];
    t2_n = t2 ^ (state_i[T2_AND_A-1] & state_i[T2_AND_B-1]) ^ state_i[T2_X-1];
    t3_n = t3 ^ (state_i[T3_AND_A-1] & state_i[T3_AND_B-1]) ^ state_i[T3_X-1];
    next_state_o = {state_i[STATE_W-2:REG_B_END], t2_n,
                    state_i[REG_B_END-2:REG_A_END], t1_n,
                    state_i[REG_A_END-2:0], t3_n};
  end
endmodule

// File: rtl/trivium_core.sv
// trivium_core: Trivium keystream generator; clk_i/rst_i/ce_i, key_i/iv_i + start_i/stop_i in, busy_o, ks_valid_o/ks_o/ks_ready_i handshake out
module trivium_core
  import trivium_pkg::*;
#(
  parameter int KEY_SZ = 80,
  parameter int IV_SZ = 80,
  parameter int INIT_ROUNDS = INIT_ROUNDS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ce_i,
  input  logic [KEY_SZ-1:0] key_i,
  input  logic [IV_SZ-1:0]  iv_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              busy_o,
  output logic              ks_valid_o,
  output logic              ks_o,
  input  logic              ks_ready_i
);
  localparam int CW = $clog2(INIT_ROUNDS);
  state_e fsm_q, fsm_d;
  logic [STATE_W-1:0] s_q, s_d, s_nxt, s_load;
  logic [CW-1:0] cnt_q, cnt_d;
  trivium_round u_round (.state_i(s_q), .next_state_o(s_nxt), .z_o(ks_o));
  always_comb begin
    s_load = '0;
    s_load[KEY_SZ-1:0] = key_i;
    s_load[REG_A_END +: IV_SZ] = iv_i;
    s_load[STATE_W-1 -: 3] = 3'b111;
  end
  always_comb begin
    fsm_d = fsm_q;
    s_d = s_q;
    cnt_d = cnt_q;
    if (ce_i) begin
      if (stop_i) begin
        fsm_d = IDLE;
      end else if (start_i) begin
        fsm_d = INIT;
        s_d = s_load;
        cnt_d = '0;
      end else if (fsm_q == INIT) begin
        s_d = s_nxt;
        cnt_d = cnt_q + 1'b1;
        fsm_d = (cnt_q == CW'(INIT_ROUNDS - 1)) ? RUN : INIT;
      end else if (fsm_q == RUN && ks_ready_i) begin
        s_d = s_nxt;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q <= IDLE;
      s_q <= '0;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy_o = fsm_q == INIT;
  assign ks_valid_o = fsm_q == RUN;
endmodule
